// File: rtl/exec_pkg.sv
// Shared definitions for the execution-stage multiply/divide unit:
// op encodings, FSM state encoding, width and divide-by-zero constant.
package exec_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// W-bit add/subtract step shared by the multiply accumulate and the divide
// trial subtraction; cout is the carry out (for subtract, 1 means no borrow).
module muldiv_addsub #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] full;

    always_comb begin
        full = {1'b0, x} + {1'b0, y ^ {W{sub}}} + {{W{1'b0}}, sub};
    end

    assign sum  = full[W-1:0];
    assign cout = full[W];

endmodule

// File: rtl/exec_muldiv.sv
// Iterative 32-bit multiply/divide: one shift-add or restoring shift-subtract
// step per cycle, then a sign fix-up cycle that writes HI/LO.
module exec_muldiv #(
    parameter int unsigned WIDTH = exec_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import exec_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic               b_zero;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    logic               accept;
    logic               op_signed;
    logic               op_div;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     as_x;
    logic [WIDTH:0]     as_y;
    logic [WIDTH:0]     as_sum;
    logic               as_cout;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_div    = (op == OP_DIV) || (op == OP_DIVU);
        abs_a     = cond_neg(a, op_signed & a[WIDTH-1]);
        abs_b     = cond_neg(b, op_signed & b[WIDTH-1]);
        accept    = (state == ST_IDLE) && start && !flush;
    end

    assign stall = busy | (start & ~flush);

    // Multiply adds opnd into the upper half; divide trial-subtracts the
    // divisor from the remainder shifted left by one quotient bit.
    always_comb begin
        if (is_div) begin
            as_x = acc[2*WIDTH-1:WIDTH-1];
            as_y = {1'b0, opnd};
        end else begin
            as_x = {1'b0, acc[2*WIDTH-1:WIDTH]};
            as_y = acc[0] ? {1'b0, opnd} : '0;
        end
    end

    muldiv_addsub #(
        .W(WIDTH + 1)
    ) u_addsub (
        .x    (as_x),
        .y    (as_y),
        .sub  (is_div),
        .sum  (as_sum),
        .cout (as_cout)
    );

    always_comb begin
        if (is_div) begin
            acc_step = {(as_cout ? as_sum[WIDTH-1:0] : as_x[WIDTH-1:0]),
                        acc[WIDTH-2:0], as_cout};
        end else begin
            acc_step = {as_sum, acc[WIDTH-1:1]};
        end
    end

    // With a zero divisor every trial succeeds, so the remainder ends as |a|
    // and its dividend-sign fix-up restores a; only LO needs overriding.
    always_comb begin
        prod = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
        if (is_div) begin
            fix_hi = cond_neg(acc[2*WIDTH-1:WIDTH], sign_a);
            fix_lo = b_zero ? DIV0_LO : cond_neg(acc[WIDTH-1:0], sign_a ^ sign_b);
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            busy <= accept || ((state != ST_IDLE) && !flush);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        is_div <= op_div;
                        sign_a <= op_signed & a[WIDTH-1];
                        sign_b <= op_signed & b[WIDTH-1];
                        b_zero <= (b == '0);
                        opnd   <= op_div ? abs_b : abs_a;
                        acc    <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                        count  <= '1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= acc_step;
                        if (count == '0) begin
                            state <= ST_FIX;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_muldiv.sv
// Self-checking bench for exec_muldiv: vector table plus scoreboard queue,
// followed by hand sequences for ignore-while-busy, flush and reset.
module tb_exec_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NVEC = 17;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   checks = 0;
    int   passes = 0;

    exec_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        logic signed [31:0] q, r;
        case (o)
            2'b00: begin
                sx = $signed(x);
                sy = $signed(y);
                return sx * sy;
            end
            2'b01: return {32'h0, x} * {32'h0, y};
            2'b10: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Drive one op, push its expectation, wait for done and check timing and result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        int   n;
        int   bc;
        exp_t e;
        op = o; a = x; b = y; flush = 1'b0; start = 1'b1;
        sb.push_back({ehi, elo});
        #1 chk({tag, "_stall_req"}, 64'(stall), 64'(1));
        @(posedge clk);
        #1 start = 1'b0;
        bc = busy ? 1 : 0;
        n  = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bc++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(33));
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(34));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
            chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_1cyc"}, 64'(done), 64'(0));
        chk({tag, "_busy_off"}, 64'(busy), 64'(0));
        chk({tag, "_stall_off"}, 64'(stall), 64'(0));
    endtask

    initial begin
        int   ndone;
        exp_t e;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'b11, 32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{2'b10, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
        vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[9]  = '{2'b01, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{2'b11, 32'h0000_0005, 32'h0000_0007, 32'h0000_0005, 32'h0000_0000};
        for (int i = 11; i < NVEC; i++) begin
            vecs[i].op = 2'($urandom_range(0, 3));
            vecs[i].a  = $urandom;
            vecs[i].b  = $urandom >> $urandom_range(0, 28);
            {vecs[i].hi, vecs[i].lo} = model(vecs[i].op, vecs[i].a, vecs[i].b);
        end

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        // A start while busy must be ignored: one done, original result.
        sb.push_back({32'h0000_0000, 32'h8000_0000});
        op = 2'b10; a = 32'h8000_0000; b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1 && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ign_hi", 64'(hi), 64'(e.hi));
                    chk("ign_lo", 64'(lo), 64'(e.lo));
                end
            end
        end
        chk("ign_done_count", 64'(ndone), 64'(1));

        // Flush mid-operation keeps the previous HI/LO.
        run_op("load", 2'b11, 32'd30, 32'd5, 32'd0, 32'd6);
        op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_stall", 64'(stall), 64'(0));
        ndone = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("flush_no_done", 64'(ndone), 64'(0));
        chk("flush_hi", 64'(hi), 64'(0));
        chk("flush_lo", 64'(lo), 64'(6));

        // start and flush together in IDLE: nothing begins.
        op = 2'b01; a = 32'd4; b = 32'd4; start = 1'b1; flush = 1'b1;
        #1 chk("sf_stall", 64'(stall), 64'(0));
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        chk("sf_busy", 64'(busy), 64'(0));
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("sf_no_activity", 64'(ndone), 64'(0));
        chk("sf_lo", 64'(lo), 64'(6));

        // Asynchronous reset in the middle of a divide.
        op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_hi", 64'(hi), 64'(0));
        chk("mid_rst_lo", 64'(lo), 64'(0));
        chk("mid_rst_stall", 64'(stall), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_rst", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
